execute_md: RTL
===============

EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameter W, default 32: datapath width, with W >= 8.
REQ-002 Parameter CNT_W, default $clog2(W)+1: width of the mul/div iteration counter.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  ID/EX holds a valid instruction.
REQ-006 data_1, data_2, imm  in  W  rs value, rt value, sign-extended immediate (imm[5:0] is the function code).
REQ-007 rs, rt, rd  in  5  register specifiers.
REQ-008 ex  in  4  {reg_dst, alu_op[1:0], alu_src}.
REQ-009 md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO.
REQ-010 m_ex  in  3 and wb_ex  in  2  downstream control; wb_ex[0] is reg_write.
REQ-011 wb_data  in  W, wb_rd  in  5, wb_reg_write  in  1  MEM/WB forwarding source.
REQ-012 stall  out  1  upstream holds ID/EX and must not advance.
REQ-013 out_valid, zero  out  1 each; res, write_data_ex  out  W; write_register  out  5; m_mem  out  3; wb_mem  out  2.  These form the EX/MEM register.

Function
REQ-014 Forward operand A from EX/MEM res when wb_mem[0] && out_valid && write_register!=0 && write_register==rs.
REQ-015 Otherwise forward operand A from wb_data when wb_reg_write && wb_rd!=0 && wb_rd==rs; otherwise use data_1.
REQ-016 Operand B (rt) follows the rules of REQ-014/REQ-015 independently, falling back to data_2.
REQ-017 write_data_ex is the forwarded rt value.
REQ-018 ALU operand 2 is imm when alu_src=1, else forwarded rt.
REQ-019 ALU control: alu_op 0 is ADD; 1 is SUB; 2 decodes funct (32 ADD, 34 SUB, 36 AND, 37 OR, 39 NOR, 42 SLT); any other value gives res=0.
REQ-020 SLT is a signed comparison; ADD/SUB wrap modulo 2^W; zero=(ALU result==0).
REQ-021 write_register is rd when reg_dst=1, else rt.
REQ-022 ALU and MFHI/MFLO instructions have 1-cycle latency: registered into EX/MEM on the next edge with out_valid=in_valid.
REQ-023 MFHI/MFLO drive res from HI/LO.
REQ-024 Mul/div FSM states: IDLE, BUSY, DONE.
REQ-025 In IDLE with in_valid and md_op in 1..4: stall=1 combinationally; forwarded operands are latched; counter=W; next state BUSY.
REQ-026 In BUSY: stall=1; one shift-add (multiply) or restoring-subtract (divide) step per cycle; counter decrements; at counter==1 write HI/LO and go to DONE.
REQ-027 In DONE: stall=0; the instruction retires to EX/MEM with out_valid=1, wb_mem=0, m_mem=0; next state IDLE.
REQ-028 Total stall for one MULT/DIV is W+1 cycles (33 for W=32).
REQ-029 Each stalled cycle loads a bubble into EX/MEM: out_valid=0, wb_mem=0, m_mem=0.
REQ-030 MULT/MULTU place the 2W-bit product as HI=upper W bits, LO=lower W bits; signed operands are handled by magnitude arithmetic with a sign fixup.
REQ-031 DIV/DIVU place quotient in LO and remainder in HI; quotient sign = XOR of operand signs, remainder sign = dividend sign.
REQ-032 Divide by zero: LO=all ones, HI=dividend, same latency, no exception.
REQ-033 MFHI/MFLO arriving while the FSM is not IDLE stall until IDLE.
REQ-034 In DONE, the HI/LO values just written are visible to the next instruction.
REQ-035 in_valid=0 produces an EX/MEM bubble and does not start the FSM.

Reset
REQ-036 rst asynchronously clears FSM to IDLE; counter, HI, LO and all outputs reset to 0; stall reads 0 while rst=1.
REQ-037 Reset during BUSY abandons the operation; HI/LO are not updated.

Structure
REQ-038 Package ex_pkg holds alu_ctrl_t, md_op_t, md_state_t enums, funct code constants and alu_op encodings.
REQ-039 Mul/div datapath and FSM is one sub-module, muldiv_unit, parametrised by W; forwarding, ALU and the EX/MEM register stay in execute_md.

Verification
REQ-040 Forwarding: wb_mem[0]=1, write_register=5, res=7, rs=5, and MEM/WB also targets 5 with 9 -> ALU uses 7.
REQ-041 rd=0 hazard: EX/MEM targets register 0 with res=3 -> operand A=data_1, unchanged.
REQ-042 MULT: -3 x 4 -> stall high for 33 cycles; then LO=0xFFFFFFF4, HI=0xFFFFFFFF; a following MFLO returns 0xFFFFFFF4.
REQ-043 DIV: -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-044 rst pulse at cycle 10 of BUSY -> stall=0 and all outputs 0 immediately; HI/LO=0; the next MULT runs full latency.
REQ-045 SLT: 0xFFFFFFFF vs 1 -> res=1; NOR of 0 and 0 -> res=0xFFFFFFFF, zero=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and encodings for the execute stage and its mul/div unit.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_NONE
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MFHI  = 3'd5,
    MD_MFLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_t;

  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_NOR = 6'd39;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_RTYPE = 2'd2;

  // True for the four opcodes that launch an iterative operation.
  function automatic logic is_md_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the HI/LO move opcodes.
  function automatic logic is_md_move(input logic [2:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers. One shift-add or
// restoring-subtract step per cycle on operand magnitudes; signs are
// applied when HI/LO are written.
module muldiv_unit import ex_pkg::*; #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [2:0]   md_op,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         stall,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  // working registers, only meaningful between launch and DONE
  logic [W-1:0] acc_hi, acc_lo, mcand, dividend;
  logic         is_div, neg_q, neg_r, div_zero;

  logic         start, signed_op, neg_a, neg_b;
  logic [W-1:0] mag_a, mag_b;
  logic [W-1:0] step_hi, step_lo;
  logic [W:0]   mul_sum, div_shift;
  logic [W-1:0] div_diff;
  logic         div_ge;
  logic [W-1:0] fin_hi, fin_lo;
  logic [2*W-1:0] prod_fix;

  function automatic logic [W-1:0] neg_w(input logic n, input logic [W-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic n, input logic [2*W-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign start = (state == MD_IDLE) && in_valid && is_md_start(md_op);
  assign done  = (state == MD_DONE);

  // Hold ID/EX while launching, iterating, or when a HI/LO move must wait.
  assign stall = !rst && (start || (state == MD_BUSY) ||
                          (in_valid && is_md_move(md_op) && (state != MD_IDLE)));

  // Operand magnitudes and signs at launch.
  always_comb begin
    signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
    neg_a     = signed_op && op_a[W-1];
    neg_b     = signed_op && op_b[W-1];
    mag_a     = neg_w(neg_a, op_a);
    mag_b     = neg_w(neg_b, op_b);
  end

  // One iteration step and the sign-fixed final HI/LO values.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_diff  = div_shift[W-1:0] - mcand;
    if (is_div) begin
      step_hi = div_ge ? div_diff : div_shift[W-1:0];
      step_lo = {acc_lo[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end
    prod_fix = neg_2w(neg_q, {step_hi, step_lo});
    if (!is_div) begin
      fin_hi = prod_fix[2*W-1:W];
      fin_lo = prod_fix[W-1:0];
    end else if (div_zero) begin
      fin_hi = dividend;
      fin_lo = {W{1'b1}};
    end else begin
      fin_hi = neg_w(neg_r, step_hi);
      fin_lo = neg_w(neg_q, step_lo);
    end
  end

  // FSM, iteration counter and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            cnt   <= CNT_W'(W);
            state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            state <= MD_DONE;
          end
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  // Working datapath: loaded at launch, stepped while busy.
  always_ff @(posedge clk) begin
    if (start) begin
      is_div   <= (md_op == MD_DIV) || (md_op == MD_DIVU);
      acc_hi   <= '0;
      acc_lo   <= mag_a;
      mcand    <= mag_b;
      neg_q    <= neg_a ^ neg_b;
      neg_r    <= neg_a;
      div_zero <= (op_b == '0);
      dividend <= op_a;
    end else if (state == MD_BUSY) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

endmodule

// File: rtl/execute_md.sv
// Execute stage: operand forwarding, ALU, HI/LO moves, the mul/div unit
// and the EX/MEM pipeline register.
module execute_md import ex_pkg::*; #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] data_1,
  input  logic [W-1:0] data_2,
  input  logic [W-1:0] imm,
  input  logic [4:0]   rs,
  input  logic [4:0]   rt,
  input  logic [4:0]   rd,
  input  logic [3:0]   ex,
  input  logic [2:0]   md_op,
  input  logic [2:0]   m_ex,
  input  logic [1:0]   wb_ex,
  input  logic [W-1:0] wb_data,
  input  logic [4:0]   wb_rd,
  input  logic         wb_reg_write,
  output logic         stall,
  output logic         out_valid,
  output logic         zero,
  output logic [W-1:0] res,
  output logic [W-1:0] write_data_ex,
  output logic [4:0]   write_register,
  output logic [2:0]   m_mem,
  output logic [1:0]   wb_mem
);

  logic        reg_dst, alu_src;
  logic [1:0]  alu_op;
  alu_ctrl_t   alu_ctrl;

  logic [W-1:0]        fwd_a, fwd_b;
  logic signed [W-1:0] alu_a, alu_b, alu_res;
  logic [W-1:0]        res_next, hi, lo;
  logic                md_done;

  assign reg_dst = ex[3];
  assign alu_op  = ex[2:1];
  assign alu_src = ex[0];

  // EX/MEM takes priority over MEM/WB; register 0 never forwards.
  function automatic logic [W-1:0] fwd_sel(input logic [4:0] src, input logic [W-1:0] dflt);
    if (wb_mem[0] && out_valid && (write_register != 5'd0) && (write_register == src))
      return res;
    else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == src))
      return wb_data;
    else
      return dflt;
  endfunction

  // Forwarded operands.
  always_comb begin
    fwd_a = fwd_sel(rs, data_1);
    fwd_b = fwd_sel(rt, data_2);
  end

  // ALU control decode.
  always_comb begin
    alu_ctrl = ALU_NONE;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (imm[5:0])
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_NOR: alu_ctrl = ALU_NOR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_NONE;
        endcase
      end
      default: alu_ctrl = ALU_NONE;
    endcase
  end

  // ALU datapath and result selection.
  always_comb begin
    alu_a = fwd_a;
    alu_b = alu_src ? imm : fwd_b;
    case (alu_ctrl)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_NOR: alu_res = ~(alu_a | alu_b);
      ALU_SLT: alu_res = (alu_a < alu_b) ? W'(1) : '0;
      default: alu_res = '0;
    endcase
    if (md_op == MD_MFHI)      res_next = hi;
    else if (md_op == MD_MFLO) res_next = lo;
    else                       res_next = alu_res;
  end

  muldiv_unit #(.W(W), .CNT_W(CNT_W)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .md_op    (md_op),
    .op_a     (fwd_a),
    .op_b     (fwd_b),
    .stall    (stall),
    .done     (md_done),
    .hi       (hi),
    .lo       (lo)
  );

  // EX/MEM register: bubbles on stall or idle slot; a finished mul/div
  // retires without memory or register-write side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      zero           <= 1'b0;
      res            <= '0;
      write_data_ex  <= '0;
      write_register <= '0;
      m_mem          <= '0;
      wb_mem         <= '0;
    end else begin
      res            <= res_next;
      zero           <= (alu_res == '0);
      write_data_ex  <= fwd_b;
      write_register <= reg_dst ? rd : rt;
      if (stall || !in_valid) begin
        out_valid <= 1'b0;
        m_mem     <= '0;
        wb_mem    <= '0;
      end else if (md_done) begin
        out_valid <= 1'b1;
        m_mem     <= '0;
        wb_mem    <= '0;
      end else begin
        out_valid <= 1'b1;
        m_mem     <= m_ex;
        wb_mem    <= wb_ex;
      end
    end
  end

endmodule
